// File: rtl/mdr_pkg.sv
// MDR shared types: operand width, opcodes, loader FSM states.
// Command-byte validation helper for the operand loader.
package mdr_pkg;

  localparam int DW = 16;
  localparam int BYTES_PER_OP = DW / 8;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MUL  = 2'd1,
    OP_DIV  = 2'd2,
    OP_SQRT = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    LAUNCH,
    WAIT_DONE
  } ldr_state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == 8'd1) || (b == 8'd2) || (b == 8'd3);
  endfunction

endpackage

// File: rtl/mdr_operand_loader_if.sv
// Loader bus: UART byte input, core handshake and operand outputs.
// master = loader side, slave = UART/core side.
interface mdr_operand_loader_if
  import mdr_pkg::*;
#(
  parameter int DW = mdr_pkg::DW
);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          core_ready;
  op_e           op_code;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          start;
  logic          busy;
  logic          err;

  modport master (
    input  rx_data, rx_valid, core_ready,
    output op_code, op_a, op_b, start, busy, err
  );

  modport slave (
    output rx_data, rx_valid, core_ready,
    input  op_code, op_a, op_b, start, busy, err
  );

endinterface

// File: rtl/mdr_operand_loader_timer.sv
// mdr_byte_timer: inter-byte idle counter with saturating expiry flag.
// Clear wins over enable; counting stops once TIMEOUT_CYC is reached.
module mdr_byte_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign expired_o = (cnt_q == TW'(TIMEOUT_CYC));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mdr_operand_loader.sv
// Assembles CMD + operand bytes into op_code/op_a/op_b, pulses start,
// and holds the operands until the selected core reports ready.
module mdr_operand_loader
  import mdr_pkg::*;
#(
  parameter int DW          = mdr_pkg::DW,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic                 clk,
  input logic                 rst,
  mdr_operand_loader_if.master bus
);

  localparam int BPO = DW / 8;
  localparam int CW  = (BPO > 1) ? $clog2(BPO) : 1;

  ldr_state_e    state_q, state_d;
  op_e           opcode_q;
  op_e           op_code_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] sa_q, sa_d;
  logic [DW-1:0] sb_q, sb_d;
  logic [DW-1:0] op_a_q, op_b_q;
  logic          err_q, err_d;
  logic          start_o, busy_o;
  logic          rx, in_get, last, expired, cmd_ok;

  assign rx     = bus.rx_valid;
  assign in_get = (state_q == GET_A) || (state_q == GET_B);
  assign last   = (cnt_q == CW'(BPO - 1));
  assign cmd_ok = is_cmd(bus.rx_data);

  mdr_byte_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_get || rx),
    .en_i     (in_get),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (rx && cmd_ok) state_d = GET_A;
      GET_A:
        if (rx) begin
          if (last)
            state_d = (opcode_q == OP_SQRT) ? LAUNCH : GET_B;
        end else if (expired) begin
          state_d = IDLE;
        end
      GET_B:
        if (rx) begin
          if (last) state_d = LAUNCH;
        end else if (expired) begin
          state_d = IDLE;
        end
      LAUNCH:
        state_d = WAIT_DONE;
      WAIT_DONE:
        if (bus.core_ready) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // any byte after the frame is complete is an overrun, even alongside core_ready
  always_comb begin
    start_o = (state_q == LAUNCH) && !rst;
    busy_o  = (state_q != IDLE);
    err_d   = 1'b0;
    unique case (1'b1)
      (state_q == IDLE):  err_d = rx && !cmd_ok;
      in_get:             err_d = !rx && expired;
      default:            err_d = rx;
    endcase
  end

  always_comb begin
    sa_d = sa_q;
    sb_d = sb_q;
    if (state_q == GET_A && rx) sa_d = {sa_q[DW-9:0], bus.rx_data};
    if (state_q == GET_B && rx) sb_d = {sb_q[DW-9:0], bus.rx_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= OP_NONE;
      op_code_q <= OP_NONE;
      cnt_q     <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      if (state_q == IDLE && rx && cmd_ok) begin
        opcode_q <= op_e'(bus.rx_data[1:0]);
        cnt_q    <= '0;
        sa_q     <= '0;
        sb_q     <= '0;
      end
      if (in_get && rx)
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (in_get && state_d == LAUNCH) begin
        op_a_q    <= sa_d;
        op_b_q    <= sb_d;
        op_code_q <= opcode_q;
      end
    end
  end

  assign bus.op_code = op_code_q;
  assign bus.op_a    = op_a_q;
  assign bus.op_b    = op_b_q;
  assign bus.start   = start_o;
  assign bus.busy    = busy_o;
  assign bus.err     = err_q;

endmodule
